// File: rtl/uart_tx_arb4.sv
// uart_tx_arb4: 4-way round-robin arbiter in front of one UART transmitter.
// Launches the winner's byte, waits for tx_done or a timeout, then acks.
module uart_tx_arb4 #(
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic        ack_err,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  localparam int CW = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [1:0]    rr_ptr;
  logic [1:0]    win;
  logic [1:0]    gsel;
  logic [CW-1:0] wait_cnt;
  logic          arb;
  logic          to_err;

  // Lowest offset from rr_ptr wins: scan high to low, last hit sticks.
  always_comb begin
    win = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[rr_ptr + 2'(i)]) win = rr_ptr + 2'(i);
    end
  end

  always_comb begin
    state_nx = state;
    arb      = 1'b0;
    to_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = LAUNCH;
          arb      = 1'b1;
        end
      end
      LAUNCH: state_nx = WAIT;
      WAIT: begin
        if (tx_done) begin
          state_nx = DONE;
        end else if (wait_cnt == CNT_MAX) begin
          state_nx = DONE;
          to_err   = 1'b1;
        end
      end
      DONE: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      gsel        <= '0;
      wait_cnt    <= '0;
      grant       <= '0;
      ack         <= '0;
      ack_err     <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      tx_start <= arb;
      busy     <= (state_nx != IDLE);
      ack      <= '0;
      ack_err  <= 1'b0;
      if (arb) begin
        gsel     <= win;
        grant    <= 4'b0001 << win;
        tx_data  <= req_data[{win, 3'b000} +: 8];
        wait_cnt <= '0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (state_nx == DONE) begin
          ack     <= grant;
          ack_err <= to_err;
        end
      end
      if (state == DONE) begin
        grant  <= '0;
        rr_ptr <= gsel + 2'd1;
      end
      if (to_err && timeout_cnt != 8'hFF) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb4.sv
// tb_uart_tx_arb4: random transfers against a round-robin reference model.
// Expected launches/acks are queued; a negedge monitor pops and compares.
module tb_uart_tx_arb4;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        ack_err;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [7:0]  timeout_cnt;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_start[$];
  logic [4:0]  exp_ack[$];

  logic [3:0] pend = '0;
  int         rr = 0;
  int         tmo = 0;
  int         tot_to = 0;
  logic [7:0] last_b = '0;

  uart_tx_arb4 #(.TIMEOUT_CLKS(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .ack         (ack),
    .ack_err     (ack_err),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int winner();
    for (int k = 0; k < 4; k++) begin
      if (pend[(rr + k) % 4]) return (rr + k) % 4;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tx_start === 1'b1) begin
        if (exp_start.size() == 0) begin
          chk("unexp_start", 32'(tx_start), 32'd0);
        end else begin
          logic [11:0] e;
          e = exp_start.pop_front();
          chk("mon_grant", 32'(grant), 32'(e[11:8]));
          chk("mon_tx_data", 32'(tx_data), 32'(e[7:0]));
        end
      end
      if (ack !== 4'b0000) begin
        if (exp_ack.size() == 0) begin
          chk("unexp_ack", 32'(ack), 32'd0);
        end else begin
          logic [4:0] a;
          a = exp_ack.pop_front();
          chk("mon_ack", 32'(ack), 32'(a[4:1]));
          chk("mon_ack_err", 32'(ack_err), 32'(a[0]));
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the next idle negedge.
  task automatic txn(input logic [3:0] add, input int n, input bit to,
                     input bit wd);
    int         g;
    logic [7:0] b;
    logic [3:0] oh;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_ack", 32'(ack), 32'd0);
    chk("idle_ack_err", 32'(ack_err), 32'd0);
    chk("idle_start", 32'(tx_start), 32'd0);
    chk("idle_tx_data", 32'(tx_data), 32'(last_b));
    for (int i = 0; i < 4; i++) begin
      if (add[i] && !pend[i]) begin
        pend[i] = 1'b1;
        req_data[i*8 +: 8] = 8'($urandom);
      end
    end
    req = pend;
    if (pend == 4'b0000) begin
      @(negedge clk);
      return;
    end
    if (to) n = TMO;
    g  = winner();
    b  = req_data[g*8 +: 8];
    oh = 4'b0001 << g;
    exp_start.push_back({oh, b});
    exp_ack.push_back({oh, to});
    @(negedge clk);
    chk("start_lat", 32'(tx_start), 32'd1);
    chk("launch_busy", 32'(busy), 32'd1);
    tx_done = 1'($urandom);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      chk("wait_start", 32'(tx_start), 32'd0);
      chk("wait_grant", 32'(grant), 32'(oh));
      chk("wait_tx_data", 32'(tx_data), 32'(b));
      chk("wait_ack", 32'(ack), 32'd0);
      tx_done = !to && (c == n);
      if (wd && c == 1) begin
        pend[g] = 1'b0;
        req[g]  = 1'b0;
        req_data[g*8 +: 8] = ~b;
      end
    end
    @(negedge clk);
    tx_done = 1'b0;
    chk("ack_lat", 32'(ack), 32'(oh));
    chk("done_grant", 32'(grant), 32'(oh));
    if (to) begin
      tot_to++;
      if (tmo < 255) tmo++;
    end
    chk("tmo_cnt", 32'(timeout_cnt), 32'(tmo));
    pend[g] = 1'b0;
    req[g]  = 1'b0;
    rr      = (g + 1) % 4;
    last_b  = b;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tmo", 32'(timeout_cnt), 32'd0);
    rst_n = 1'b1;

    req_data[23:16] = 8'hA5;
    pend[2] = 1'b1;
    txn(4'b0000, 12, 1'b0, 1'b0);

    repeat (5) txn(4'b1111, $urandom_range(1, 10), 1'b0, 1'b0);
    while (pend != 4'b0000) txn(4'b0000, $urandom_range(1, 10), 1'b0, 1'b0);
    txn(4'b0100, 3, 1'b0, 1'b0);
    txn(4'b1001, 3, 1'b0, 1'b0);
    txn(4'b0000, 3, 1'b0, 1'b0);

    txn(4'b0001, TMO, 1'b0, 1'b0);
    txn(4'b0010, TMO, 1'b1, 1'b0);

    for (int it = 0; it < 150; it++) begin
      logic [3:0] add;
      bit         to;
      int         n;
      add = 4'($urandom);
      if ((pend | add) == 4'b0000) begin
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
        add = 4'b0001 << $urandom_range(0, 3);
      end
      to = ($urandom_range(0, 3) == 0);
      n  = ($urandom_range(0, 4) == 0) ? TMO : $urandom_range(1, TMO - 1);
      txn(add, n, to, $urandom_range(0, 5) == 0);
    end

    pend = 4'b0001;
    req  = pend;
    req_data[7:0] = 8'h3C;
    exp_start.push_back({4'b0001, 8'h3C});
    @(negedge clk);
    chk("rst2_start", 32'(tx_start), 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_grant", 32'(grant), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_tx_data", 32'(tx_data), 32'd0);
    chk("rst2_tmo", 32'(timeout_cnt), 32'd0);
    chk("rst2_ack", 32'(ack), 32'd0);
    pend   = '0;
    req    = '0;
    rr     = 0;
    tmo    = 0;
    tot_to = 0;
    last_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    txn(4'b0010, 5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_rst_ack", 32'(ack), 32'd0);

    while (tot_to < 300) begin
      logic [3:0] add;
      add = 4'($urandom);
      if ((pend | add) == 4'b0000) add = 4'b1000;
      txn(add, TMO, 1'b1, 1'b0);
    end
    chk("tmo_sat", 32'(timeout_cnt), 32'd255);
    chk("q_start_empty", 32'(exp_start.size()), 32'd0);
    chk("q_ack_empty", 32'(exp_ack.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
